// File: rtl/axi4_arch_drop_sender.sv
// AR channel stage of the remapping block.
// Incoming AR requests are queued while the translation lookup resolves.
// Each decision then either forwards the head request with its translated
// address, or drops it with a one-cycle trans_drop pulse toward the
// read-response sender.
module axi4_arch_drop_sender #(
    parameter int C_AXI_ADDR_WIDTH = 32,
    parameter int C_AXI_ID_WIDTH   = 4,
    parameter int C_AXI_USER_WIDTH = 4,
    parameter int C_PEND_DEPTH     = 4
) (
    input  logic                        axi4_aclk,
    input  logic                        axi4_arstn,
    // slave-side AR
    input  logic [C_AXI_ADDR_WIDTH-1:0] s_axi4_araddr,
    input  logic [C_AXI_ID_WIDTH-1:0]   s_axi4_arid,
    input  logic [7:0]                  s_axi4_arlen,
    input  logic [2:0]                  s_axi4_arsize,
    input  logic [1:0]                  s_axi4_arburst,
    input  logic                        s_axi4_arlock,
    input  logic [3:0]                  s_axi4_arcache,
    input  logic [2:0]                  s_axi4_arprot,
    input  logic [C_AXI_USER_WIDTH-1:0] s_axi4_aruser,
    input  logic                        s_axi4_arvalid,
    output logic                        s_axi4_arready,
    // lookup request
    output logic                        lookup_valid,
    output logic [C_AXI_ADDR_WIDTH-1:0] lookup_addr,
    output logic [C_AXI_ID_WIDTH-1:0]   lookup_id,
    output logic [2:0]                  lookup_prot,
    // translation decision
    input  logic                        rab_valid,
    input  logic                        rab_drop,
    input  logic [C_AXI_ADDR_WIDTH-1:0] rab_addr,
    output logic                        rab_ready,
    // master-side AR
    output logic [C_AXI_ADDR_WIDTH-1:0] m_axi4_araddr,
    output logic [C_AXI_ID_WIDTH-1:0]   m_axi4_arid,
    output logic [7:0]                  m_axi4_arlen,
    output logic [2:0]                  m_axi4_arsize,
    output logic [1:0]                  m_axi4_arburst,
    output logic                        m_axi4_arlock,
    output logic [3:0]                  m_axi4_arcache,
    output logic [2:0]                  m_axi4_arprot,
    output logic [C_AXI_USER_WIDTH-1:0] m_axi4_aruser,
    output logic                        m_axi4_arvalid,
    input  logic                        m_axi4_arready,
    // drop notification
    output logic                        trans_drop,
    output logic [C_AXI_ID_WIDTH-1:0]   trans_id,
    input  logic                        drop_ready,
    output logic [15:0]                 drop_cnt
);

    localparam int PW = $clog2(C_PEND_DEPTH);
    localparam int EW = C_AXI_ID_WIDTH + 8 + 3 + 2 + 1 + 4 + 3 + C_AXI_USER_WIDTH;

    // Pending FIFO: everything but the address, which is replaced by rab_addr
    logic [EW-1:0] mem_q [C_PEND_DEPTH];
    logic [PW:0]   wr_ptr_q, rd_ptr_q;
    logic [EW-1:0] push_entry, head_entry;
    logic          full, empty, push, pop;

    logic [C_AXI_ID_WIDTH-1:0]   h_id;
    logic [7:0]                  h_len;
    logic [2:0]                  h_size;
    logic [1:0]                  h_burst;
    logic                        h_lock;
    logic [3:0]                  h_cache;
    logic [2:0]                  h_prot;
    logic [C_AXI_USER_WIDTH-1:0] h_user;

    // Output register and drop-side state
    logic [C_AXI_ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [C_AXI_ID_WIDTH-1:0]   arid_q, arid_d;
    logic [7:0]                  arlen_q, arlen_d;
    logic [2:0]                  arsize_q, arsize_d;
    logic [1:0]                  arburst_q, arburst_d;
    logic                        arlock_q, arlock_d;
    logic [3:0]                  arcache_q, arcache_d;
    logic [2:0]                  arprot_q, arprot_d;
    logic [C_AXI_USER_WIDTH-1:0] aruser_q, aruser_d;
    logic                        arvalid_q, arvalid_d;
    logic                        trans_drop_q, trans_drop_d;
    logic [C_AXI_ID_WIDTH-1:0]   trans_id_q, trans_id_d;
    logic [15:0]                 drop_cnt_q, drop_cnt_d;

    logic out_free, fire, do_accept, do_drop;

    assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);

    assign s_axi4_arready = ~full;
    assign push           = s_axi4_arvalid & ~full;

    assign lookup_valid = push;
    assign lookup_addr  = s_axi4_araddr;
    assign lookup_id    = s_axi4_arid;
    assign lookup_prot  = s_axi4_arprot;

    assign out_free  = ~arvalid_q | m_axi4_arready;
    assign rab_ready = ~empty & out_free & drop_ready;
    assign fire      = rab_valid & rab_ready;
    assign do_accept = fire & ~rab_drop;
    assign do_drop   = fire & rab_drop;
    assign pop       = fire;

    assign push_entry = {s_axi4_arid, s_axi4_arlen, s_axi4_arsize, s_axi4_arburst,
                         s_axi4_arlock, s_axi4_arcache, s_axi4_arprot, s_axi4_aruser};
    assign head_entry = mem_q[rd_ptr_q[PW-1:0]];
    assign {h_id, h_len, h_size, h_burst, h_lock, h_cache, h_prot, h_user} = head_entry;

    // FIFO storage: written on push, never reset (pointers define validity)
    always_ff @(posedge axi4_aclk) begin
        if (push) begin
            mem_q[wr_ptr_q[PW-1:0]] <= push_entry;
        end
    end

    // FIFO pointers; the extra MSB distinguishes full from empty
    always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
        if (!axi4_arstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Next state: accept reloads the output, drop pulses and counts
    always_comb begin
        araddr_d     = araddr_q;
        arid_d       = arid_q;
        arlen_d      = arlen_q;
        arsize_d     = arsize_q;
        arburst_d    = arburst_q;
        arlock_d     = arlock_q;
        arcache_d    = arcache_q;
        arprot_d     = arprot_q;
        aruser_d     = aruser_q;
        arvalid_d    = arvalid_q & ~m_axi4_arready;
        trans_drop_d = do_drop;
        trans_id_d   = trans_id_q;
        drop_cnt_d   = drop_cnt_q;
        if (do_accept) begin
            araddr_d  = rab_addr;
            arid_d    = h_id;
            arlen_d   = h_len;
            arsize_d  = h_size;
            arburst_d = h_burst;
            arlock_d  = h_lock;
            arcache_d = h_cache;
            arprot_d  = h_prot;
            aruser_d  = h_user;
            arvalid_d = 1'b1;
        end
        if (do_drop) begin
            trans_id_d = h_id;
            if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    // Output and drop registers
    always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
        if (!axi4_arstn) begin
            araddr_q     <= '0;
            arid_q       <= '0;
            arlen_q      <= '0;
            arsize_q     <= '0;
            arburst_q    <= '0;
            arlock_q     <= 1'b0;
            arcache_q    <= '0;
            arprot_q     <= '0;
            aruser_q     <= '0;
            arvalid_q    <= 1'b0;
            trans_drop_q <= 1'b0;
            trans_id_q   <= '0;
            drop_cnt_q   <= '0;
        end else begin
            araddr_q     <= araddr_d;
            arid_q       <= arid_d;
            arlen_q      <= arlen_d;
            arsize_q     <= arsize_d;
            arburst_q    <= arburst_d;
            arlock_q     <= arlock_d;
            arcache_q    <= arcache_d;
            arprot_q     <= arprot_d;
            aruser_q     <= aruser_d;
            arvalid_q    <= arvalid_d;
            trans_drop_q <= trans_drop_d;
            trans_id_q   <= trans_id_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    assign m_axi4_araddr  = araddr_q;
    assign m_axi4_arid    = arid_q;
    assign m_axi4_arlen   = arlen_q;
    assign m_axi4_arsize  = arsize_q;
    assign m_axi4_arburst = arburst_q;
    assign m_axi4_arlock  = arlock_q;
    assign m_axi4_arcache = arcache_q;
    assign m_axi4_arprot  = arprot_q;
    assign m_axi4_aruser  = aruser_q;
    assign m_axi4_arvalid = arvalid_q;
    assign trans_drop     = trans_drop_q;
    assign trans_id       = trans_id_q;
    assign drop_cnt       = drop_cnt_q;

endmodule

// File: tb/tb_axi4_arch_drop_sender.sv
// Directed bench for axi4_arch_drop_sender: accept, drop, fill/backpressure,
// ordering under output stall, drop_ready gating, counter saturation and
// asynchronous reset.
module tb_axi4_arch_drop_sender;

    logic        clk = 1'b0;
    logic        arstn = 1'b0;
    logic [31:0] s_araddr = '0;
    logic [3:0]  s_arid = '0;
    logic [7:0]  s_arlen = '0;
    logic [2:0]  s_arsize = '0;
    logic [1:0]  s_arburst = '0;
    logic        s_arlock = 1'b0;
    logic [3:0]  s_arcache = '0;
    logic [2:0]  s_arprot = '0;
    logic [3:0]  s_aruser = '0;
    logic        s_arvalid = 1'b0;
    logic        s_arready;
    logic        lookup_valid;
    logic [31:0] lookup_addr;
    logic [3:0]  lookup_id;
    logic [2:0]  lookup_prot;
    logic        rab_valid = 1'b0;
    logic        rab_drop = 1'b0;
    logic [31:0] rab_addr = '0;
    logic        rab_ready;
    logic [31:0] m_araddr;
    logic [3:0]  m_arid;
    logic [7:0]  m_arlen;
    logic [2:0]  m_arsize;
    logic [1:0]  m_arburst;
    logic        m_arlock;
    logic [3:0]  m_arcache;
    logic [2:0]  m_arprot;
    logic [3:0]  m_aruser;
    logic        m_arvalid;
    logic        m_arready = 1'b1;
    logic        trans_drop;
    logic [3:0]  trans_id;
    logic        drop_ready = 1'b1;
    logic [15:0] drop_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    axi4_arch_drop_sender dut (
        .axi4_aclk      (clk),
        .axi4_arstn     (arstn),
        .s_axi4_araddr  (s_araddr),
        .s_axi4_arid    (s_arid),
        .s_axi4_arlen   (s_arlen),
        .s_axi4_arsize  (s_arsize),
        .s_axi4_arburst (s_arburst),
        .s_axi4_arlock  (s_arlock),
        .s_axi4_arcache (s_arcache),
        .s_axi4_arprot  (s_arprot),
        .s_axi4_aruser  (s_aruser),
        .s_axi4_arvalid (s_arvalid),
        .s_axi4_arready (s_arready),
        .lookup_valid   (lookup_valid),
        .lookup_addr    (lookup_addr),
        .lookup_id      (lookup_id),
        .lookup_prot    (lookup_prot),
        .rab_valid      (rab_valid),
        .rab_drop       (rab_drop),
        .rab_addr       (rab_addr),
        .rab_ready      (rab_ready),
        .m_axi4_araddr  (m_araddr),
        .m_axi4_arid    (m_arid),
        .m_axi4_arlen   (m_arlen),
        .m_axi4_arsize  (m_arsize),
        .m_axi4_arburst (m_arburst),
        .m_axi4_arlock  (m_arlock),
        .m_axi4_arcache (m_arcache),
        .m_axi4_arprot  (m_arprot),
        .m_axi4_aruser  (m_aruser),
        .m_axi4_arvalid (m_arvalid),
        .m_axi4_arready (m_arready),
        .trans_drop     (trans_drop),
        .trans_id       (trans_id),
        .drop_ready     (drop_ready),
        .drop_cnt       (drop_cnt)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    // advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
        s_arvalid = 1'b1;
        s_arid    = id;
        s_araddr  = addr;
        s_arlen   = len;
        s_arprot  = 3'd2;
    endtask

    task automatic set_dec(input logic drop, input logic [31:0] addr);
        rab_valid = 1'b1;
        rab_drop  = drop;
        rab_addr  = addr;
    endtask

    int pulses;

    initial begin
        // ---------------- reset state
        #12;
        check_val("rst_m_arvalid", 32'(m_arvalid), 32'd0);
        check_val("rst_m_araddr", m_araddr, 32'd0);
        check_val("rst_s_arready", 32'(s_arready), 32'd1);
        check_val("rst_rab_ready", 32'(rab_ready), 32'd0);
        check_val("rst_trans_drop", 32'(trans_drop), 32'd0);
        check_val("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        arstn = 1'b1;
        step();

        // ---------------- single accept
        set_ar(4'd3, 32'h0000_1000, 8'd7);
        #1;
        check_val("acc_lookup_valid", 32'(lookup_valid), 32'd1);
        check_val("acc_lookup_addr", lookup_addr, 32'h0000_1000);
        check_val("acc_lookup_id", 32'(lookup_id), 32'd3);
        check_val("acc_lookup_prot", 32'(lookup_prot), 32'd2);
        step();
        s_arvalid = 1'b0;
        set_dec(1'b0, 32'h8000_1000);
        #1;
        check_val("acc_rab_ready", 32'(rab_ready), 32'd1);
        check_val("acc_m_arvalid_early", 32'(m_arvalid), 32'd0);
        step();
        rab_valid = 1'b0;
        check_val("acc_m_arvalid", 32'(m_arvalid), 32'd1);
        check_val("acc_m_araddr", m_araddr, 32'h8000_1000);
        check_val("acc_m_arid", 32'(m_arid), 32'd3);
        check_val("acc_m_arlen", 32'(m_arlen), 32'd7);
        check_val("acc_m_arprot", 32'(m_arprot), 32'd2);
        check_val("acc_no_drop", 32'(trans_drop), 32'd0);
        step();
        check_val("acc_m_arvalid_clr", 32'(m_arvalid), 32'd0);

        // ---------------- single drop
        set_ar(4'd5, 32'h0000_2000, 8'd0);
        step();
        s_arvalid = 1'b0;
        set_dec(1'b1, 32'h0);
        step();
        rab_valid = 1'b0;
        check_val("drop_trans_drop", 32'(trans_drop), 32'd1);
        check_val("drop_trans_id", 32'(trans_id), 32'd5);
        check_val("drop_m_arvalid", 32'(m_arvalid), 32'd0);
        check_val("drop_cnt1", 32'(drop_cnt), 32'd1);
        step();
        check_val("drop_pulse_end", 32'(trans_drop), 32'd0);

        // ---------------- fill / backpressure
        for (int i = 0; i < 4; i++) begin
            set_ar(4'(i), 32'h100 * i, 8'd0);
            step();
        end
        check_val("fill_arready0", 32'(s_arready), 32'd0);
        set_ar(4'd4, 32'h400, 8'd0);
        #1;
        check_val("fill_5th_blocked", 32'(lookup_valid), 32'd0);
        set_dec(1'b0, 32'hA000_0000);
        #1;
        check_val("fill_rab_ready", 32'(rab_ready), 32'd1);
        check_val("fill_no_push_on_pop", 32'(s_arready), 32'd0);
        step();
        rab_valid = 1'b0;
        check_val("fill_arready1", 32'(s_arready), 32'd1);
        check_val("fill_5th_accept", 32'(lookup_valid), 32'd1);
        check_val("fill_out_id0", 32'(m_arid), 32'd0);
        step();
        s_arvalid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            set_dec(1'b0, 32'hA000_0000 + 32'(i));
            step();
            check_val($sformatf("fill_out_id%0d", i), 32'(m_arid), 32'(i));
            check_val($sformatf("fill_out_addr%0d", i), m_araddr, 32'hA000_0000 + 32'(i));
        end
        rab_valid = 1'b0;
        step();
        check_val("fill_drained_valid", 32'(m_arvalid), 32'd0);
        check_val("fill_drained_rab_ready", 32'(rab_ready), 32'd0);

        // ---------------- ordering with stall
        m_arready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            set_ar(4'(i), 32'h10 * i, 8'(i));
            step();
        end
        s_arvalid = 1'b0;
        set_dec(1'b0, 32'hB000_0001);
        step();
        check_val("ord_id1_valid", 32'(m_arvalid), 32'd1);
        check_val("ord_id1", 32'(m_arid), 32'd1);
        set_dec(1'b1, 32'h0);
        #1;
        check_val("ord_rab_ready_held", 32'(rab_ready), 32'd0);
        step();
        check_val("ord_stable_id", 32'(m_arid), 32'd1);
        check_val("ord_stable_addr", m_araddr, 32'hB000_0001);
        check_val("ord_stable_len", 32'(m_arlen), 32'd1);
        check_val("ord_no_early_drop", 32'(trans_drop), 32'd0);
        m_arready = 1'b1;
        #1;
        check_val("ord_rab_ready_free", 32'(rab_ready), 32'd1);
        step();
        check_val("ord_drop2", 32'(trans_drop), 32'd1);
        check_val("ord_drop2_id", 32'(trans_id), 32'd2);
        check_val("ord_valid_clr", 32'(m_arvalid), 32'd0);
        m_arready = 1'b0;
        set_dec(1'b0, 32'hB000_0003);
        step();
        rab_valid = 1'b0;
        check_val("ord_id3", 32'(m_arid), 32'd3);
        check_val("ord_id3_addr", m_araddr, 32'hB000_0003);
        check_val("ord_drop_once", 32'(trans_drop), 32'd0);
        step();
        check_val("ord_id3_held", 32'(m_arvalid), 32'd1);
        m_arready = 1'b1;
        step();
        check_val("ord_done", 32'(m_arvalid), 32'd0);
        check_val("ord_drop_cnt", 32'(drop_cnt), 32'd2);

        // ---------------- drop_ready gating
        set_ar(4'd6, 32'h600, 8'd0);
        step();
        set_ar(4'd7, 32'h700, 8'd0);
        step();
        s_arvalid = 1'b0;
        drop_ready = 1'b0;
        set_dec(1'b1, 32'h0);
        #1;
        check_val("dr_blocked", 32'(rab_ready), 32'd0);
        step();
        check_val("dr_no_pulse", 32'(trans_drop), 32'd0);
        drop_ready = 1'b1;
        #1;
        check_val("dr_released", 32'(rab_ready), 32'd1);
        step();
        check_val("dr_pulse6", 32'(trans_drop), 32'd1);
        check_val("dr_id6", 32'(trans_id), 32'd6);
        step();
        check_val("dr_pulse7", 32'(trans_drop), 32'd1);
        check_val("dr_id7", 32'(trans_id), 32'd7);
        rab_valid = 1'b0;
        step();
        check_val("dr_pulse_end", 32'(trans_drop), 32'd0);
        check_val("dr_drop_cnt", 32'(drop_cnt), 32'd4);

        // ---------------- counter saturation: one push + one drop per cycle
        set_ar(4'd9, 32'h900, 8'd0);
        set_dec(1'b1, 32'h0);
        pulses = 0;
        for (int i = 0; i < 65540; i++) begin
            step();
            if (trans_drop) pulses++;
        end
        check_val("sat_pulses", 32'(pulses), 32'd65539);
        check_val("sat_drop_cnt", 32'(drop_cnt), 32'h0000_FFFF);

        // ---------------- async reset mid-transfer
        m_arready = 1'b0;
        rab_drop  = 1'b0;
        step();
        check_val("ar_pre_valid", 32'(m_arvalid), 32'd1);
        s_arvalid = 1'b0;
        #2;
        arstn = 1'b0;
        #1;
        check_val("ar_valid", 32'(m_arvalid), 32'd0);
        check_val("ar_addr", m_araddr, 32'd0);
        check_val("ar_trans_drop", 32'(trans_drop), 32'd0);
        check_val("ar_drop_cnt", 32'(drop_cnt), 32'd0);
        check_val("ar_arready", 32'(s_arready), 32'd1);
        check_val("ar_rab_ready", 32'(rab_ready), 32'd0);
        #3;
        arstn = 1'b1;
        rab_drop = 1'b1;
        step();
        step();
        check_val("ar_no_drop_after", 32'(trans_drop), 32'd0);
        check_val("ar_cnt_after", 32'(drop_cnt), 32'd0);
        rab_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
